// File: rtl/posit_mul_arbiter.sv
// Round-robin arbiter sharing one combinational posit multiplier among NUM_REQ requesters.
// Optional grant/stall counters are built when POSIT_MUL_ARB_STATS_EN is defined.

module multiplier #(
  parameter int N  = 16,
  parameter int ES = 3
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] p
);
  localparam int FW = N - 1 - ES;
  localparam int SW = $clog2(N) + ES + 3;
  localparam int PW = 2 * (FW + 1);
  localparam int L  = 2 + ES + (PW - 1) + N;
  localparam logic signed [SW-1:0] MAXS = SW'((N - 2) << ES);
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  typedef struct packed {
    logic signed [SW-1:0] scale;
    logic [FW-1:0]        frac;
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] v);
    dec_t d;
    logic [N-2:0] body;
    logic [N-2:0] rem;
    logic run;
    int m;
    int s;
    body = v[N-1] ? (~v[N-2:0] + 1'b1) : v[N-2:0];
    m = 0;
    run = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (body[i] == body[N-2])) m++;
      else run = 1'b0;
    end
    rem = body << (m + 1);
    s = (body[N-2] ? (m - 1) : -m) * (2 ** ES) + int'(rem[N-2 -: ES]);
    d.scale = SW'(s);
    d.frac = rem[FW-1:0];
    return d;
  endfunction

  dec_t dx, dy;
  logic [PW-1:0] prod;
  logic [PW-2:0] mfrac;
  logic signed [SW-1:0] sc, k;
  logic [SW-1:0] sh;
  logic [L-1:0] v, vs;
  logic [N-2:0] keep, rnd_body, body;
  logic grd, stk;
  logic [N-1:0] mag;

  always_comb begin
    dx = decode(x);
    dy = decode(y);
    prod = PW'({1'b1, dx.frac}) * PW'({1'b1, dy.frac});
    sc = dx.scale + dy.scale + $signed({{(SW-1){1'b0}}, prod[PW-1]});
    mfrac = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    // regime is produced by sign-filling a 10/01 seed, so the run length is just the shift
    k = sc >>> ES;
    sh = k[SW-1] ? ~k : k;
    v = {(k[SW-1] ? 2'b01 : 2'b10), sc[ES-1:0], mfrac, {N{1'b0}}};
    vs = $signed(v) >>> sh;
    keep = vs[L-1 -: N-1];
    grd = vs[L-N];
    stk = |vs[L-N-1:0];
    rnd_body = keep + {{(N-2){1'b0}}, grd & (keep[0] | stk)};
    if (sc >= MAXS) body = '1;
    else if (sc < -MAXS) body = {{(N-2){1'b0}}, 1'b1};
    else body = rnd_body;
    mag = {1'b0, body};
    if ((x == NAR) || (y == NAR)) p = NAR;
    else if ((x == '0) || (y == '0)) p = '0;
    else p = (x[N-1] ^ y[N-1]) ? (~mag + 1'b1) : mag;
  end
endmodule

// state | meaning
// EMPTY | result register holds no product
// FULL  | result register holds a product awaiting out_ready
module posit_mul_arbiter #(
  parameter int N       = 16,
  parameter int ES      = 3,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*N-1:0] req_x,
  input  logic [NUM_REQ*N-1:0] req_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_posit,
  output logic [IDW-1:0]       out_id,
  output logic                 busy
`ifdef POSIT_MUL_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_grants,
  output logic [15:0]           stat_stalls
`endif
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t state, state_nxt;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_idx;
  logic gnt_found, grant, can_accept;
  logic [N-1:0] mul_x, mul_y, mul_p;

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign busy       = out_valid || (|req_valid);

  always_comb begin : p_arb
    int idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      idx = int'(rr_ptr) + j;
      if (idx >= NUM_REQ) idx -= NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  // rst_n gates the grant so nothing is acknowledged while reset is held
  assign grant     = rst_n && can_accept && gnt_found;
  assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

  assign mul_x = req_x[gnt_idx*N +: N];
  assign mul_y = req_y[gnt_idx*N +: N];

  multiplier #(.N(N), .ES(ES)) u_mul (
    .x(mul_x),
    .y(mul_y),
    .p(mul_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (!grant && out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_posit <= '0;
      out_id    <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      out_posit <= mul_p;
      out_id    <= gnt_idx;
      rr_ptr    <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

`ifdef POSIT_MUL_ARB_STATS_EN
  logic [15:0] stall_cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [15:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    cnt <= '0;
      else if (req_ready[i] && (cnt != 16'hFFFF))    cnt <= cnt + 16'd1;
    end
    assign stat_grants[i*16 +: 16] = cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if ((|req_valid) && !can_accept && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
  assign stat_stalls = stall_cnt;
`endif
endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Bench for posit_mul_arbiter: directed steps plus random traffic against a real-valued posit model.
module tb_posit_mul_arbiter;
  localparam int N = 16;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*N-1:0] req_x, req_y;
  logic out_valid, out_ready, busy;
  logic [N-1:0] out_posit;
  logic [1:0] out_id;
`ifdef POSIT_MUL_ARB_STATS_EN
  logic [NR*16-1:0] stat_grants;
  logic [15:0] stat_stalls;
`endif

  int vectors = 0;
  int miscompares = 0;

  bit mv;
  logic [15:0] mp;
  int mid, mptr;
  int g;

  always #5 clk = ~clk;

  posit_mul_arbiter #(.N(16), .ES(3), .NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_posit(out_posit), .out_id(out_id), .busy(busy)
`ifdef POSIT_MUL_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int s);
    real r = 1.0;
    if (s >= 0) for (int i = 0; i < s; i++) r = r * 2.0;
    else for (int i = 0; i < -s; i++) r = r / 2.0;
    return r;
  endfunction

  // value of a non-zero, non-NaR posit<16,3>
  function automatic real pdec(input logic [15:0] p);
    logic [15:0] a;
    int i, m, k, e;
    real f, w;
    a = p[15] ? (~p + 16'd1) : p;
    i = 14; m = 0;
    while (i >= 0 && a[i] == a[14]) begin m++; i--; end
    k = a[14] ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < 3; j++) begin
      e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
      i--;
    end
    f = 1.0; w = 0.5;
    while (i >= 0) begin
      if (a[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    return (p[15] ? -1.0 : 1.0) * f * pow2(8 * k + e);
  endfunction

  // nearest posit<16,3> by rounding the infinite bit string, ties to even, no underflow/overflow
  function automatic logic [15:0] penc(input real v);
    real a, f;
    int sc, k, e, len;
    bit s, b, grd, stk;
    logic [63:0] str;
    logic [14:0] keep;
    logic [15:0] body;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    a = s ? -v : v;
    sc = 0;
    while (a >= 2.0) begin a = a / 2.0; sc++; end
    while (a < 1.0) begin a = a * 2.0; sc--; end
    if (sc >= 112) body = 16'h7FFF;
    else if (sc < -112) body = 16'h0001;
    else begin
      k = (sc >= 0) ? sc / 8 : -((-sc + 7) / 8);
      e = sc - 8 * k;
      str = '0; len = 0;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin str = {str[62:0], 1'b1}; len++; end
        str = {str[62:0], 1'b0}; len++;
      end else begin
        for (int i = 0; i < -k; i++) begin str = {str[62:0], 1'b0}; len++; end
        str = {str[62:0], 1'b1}; len++;
      end
      for (int i = 2; i >= 0; i--) begin str = {str[62:0], ((e >> i) & 1) != 0}; len++; end
      f = a - 1.0;
      for (int i = 0; i < 30; i++) begin
        f = f * 2.0;
        b = (f >= 1.0);
        if (b) f = f - 1.0;
        str = {str[62:0], b}; len++;
      end
      keep = 15'(str >> (len - 15));
      grd = str[len - 16];
      stk = ((str & ((64'd1 << (len - 16)) - 64'd1)) != 0) || (f != 0.0);
      body = {1'b0, keep} + 16'(grd & (keep[0] | stk));
    end
    return s ? (~body + 16'd1) : body;
  endfunction

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    if (x == 16'h8000 || y == 16'h8000) return 16'h8000;
    if (x == 16'h0000 || y == 16'h0000) return 16'h0000;
    return penc(pdec(x) * pdec(y));
  endfunction

  function automatic logic [15:0] rnd_posit();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'h8000;
    return 16'($urandom());
  endfunction

  task automatic model_reset();
    mv = 0; mp = '0; mid = 0; mptr = 0;
  endtask

  // called at a falling edge with inputs applied; checks, advances the model, ends at next falling edge
  task automatic cycle(output int gnt);
    bit can;
    int idx;
    logic [3:0] exp_rdy;
    #1;
    can = !mv || out_ready;
    gnt = -1;
    if (can)
      for (int j = 0; j < NR; j++) begin
        idx = (mptr + j) % NR;
        if (gnt < 0 && req_valid[idx]) gnt = idx;
      end
    exp_rdy = (gnt >= 0) ? 4'(1 << gnt) : 4'b0000;
    check("req_ready", req_ready, exp_rdy);
    check("out_valid", out_valid, mv);
    check("out_posit", out_posit, mp);
    check("out_id", out_id, mid);
    check("busy", busy, mv || (|req_valid));
    if (gnt >= 0) begin
      mv = 1;
      mp = ref_mul(req_x[gnt*N +: N], req_y[gnt*N +: N]);
      mid = gnt;
      mptr = (gnt + 1) % NR;
    end else if (out_ready) mv = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input logic [15:0] x, input logic [15:0] y);
    req_valid[i] = v;
    req_x[i*N +: N] = x;
    req_y[i*N +: N] = y;
  endtask

  logic [15:0] ys [4] = '{16'h5000, 16'h3A21, 16'h6B42, 16'h2C63};
  logic [15:0] sx [3] = '{16'h0000, 16'h8000, 16'h8000};
  logic [15:0] sy [3] = '{16'h6AD5, 16'h2D15, 16'h0000};
  logic [15:0] sr [3] = '{16'h0000, 16'h8000, 16'h8000};

  initial begin
    rst_n = 1'b0;
    req_valid = 4'b1111;
    req_x = '0; req_y = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_ready", req_ready, 4'b0000);
    check("rst_valid", out_valid, 1'b0);
    check("rst_posit", out_posit, 16'h0000);
    check("rst_id", out_id, 2'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // single request with identity operand
    out_ready = 1'b1;
    set_req(0, 1, 16'h4000, 16'hAD15);
    cycle(g);
    check("id_valid", out_valid, 1'b1);
    check("id_posit", out_posit, 16'hAD15);
    check("id_id", out_id, 2'd0);
    req_valid = '0;
    cycle(g);
    check("id_drop", out_valid, 1'b0);

    // round robin with all requesters held valid
    for (int i = 0; i < NR; i++) set_req(i, 1, 16'h4000, ys[i]);
    for (int c = 0; c < 8; c++) begin
      cycle(g);
      check("rr_order", g, (1 + c) % NR);
      check("rr_posit", out_posit, ys[(1 + c) % NR]);
    end
    req_valid = '0;
    cycle(g);

    // backpressure
    set_req(1, 1, 16'hC000, 16'h4000);
    cycle(g);
    check("bp_posit", out_posit, 16'hC000);
    out_ready = 1'b0;
    set_req(3, 1, 16'h4000, 16'h4800);
    for (int c = 0; c < 3; c++) begin
      cycle(g);
      check("bp_hold", out_posit, 16'hC000);
    end
    out_ready = 1'b1;
    cycle(g);
    check("bp_regrant", out_valid, 1'b1);
    req_valid = '0;
    cycle(g);

    // special values
    for (int s = 0; s < 3; s++) begin
      set_req(0, 1, sx[s], sy[s]);
      cycle(g);
      check("special", out_posit, sr[s]);
      req_valid = '0;
    end
    cycle(g);

    // randomized traffic
    g = -1;
    for (int r = 0; r < 400; r++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] || g == i)
          set_req(i, $urandom_range(0, 99) < 55, rnd_posit(), rnd_posit());
      out_ready = ($urandom_range(0, 99) < 70);
      cycle(g);
    end

    // reset while a result is pending
    set_req(0, 1, 16'h4000, 16'h5000);
    set_req(2, 1, 16'h4000, 16'h5100);
    out_ready = 1'b0;
    cycle(g);
    cycle(g);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", req_ready, 4'b0000);
    model_reset();
    @(negedge clk);
    req_valid = 4'b0110;
    out_ready = 1'b1;
    rst_n = 1'b1;
    cycle(g);
    check("post_rst_grant", g, 1);
    req_valid = '0;
    cycle(g);

`ifdef POSIT_MUL_ARB_STATS_EN
    rst_n = 1'b0;
    #1;
    check("stat_rst", stat_stalls, 16'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(2, 1, 16'h4000, 16'h5000);
    for (int c = 0; c < 5; c++) cycle(g);
    req_valid = '0;
    out_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) cycle(g);
    check("stat_grants2", stat_grants[2*16 +: 16], 16'd5);
    check("stat_stalls", stat_stalls, 16'd3);
    out_ready = 1'b1;
    for (int c = 0; c < 70000; c++) @(negedge clk);
    check("stat_sat", stat_grants[2*16 +: 16], 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
